// File: rtl/alu_seq_pkg.sv
// Shared encodings for the multi-word ALU sequencer: op codes, FSM states,
// the ALU word width and the per-word ALU control bundle.
package alu_seq_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_ADC = 2'd2,
      OP_SBB = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic sub;
      logic sbb;
      logic adc;
      logic c;
   } alu_ctl_t;

endpackage

// File: rtl/alu_mw_ctl_decode.sv
// Per-word ALU control decode: the first word starts the chain from the op
// itself, later words always chain through the saved carry.
module alu_mw_ctl_decode
   import alu_seq_pkg::*;
(
   input  op_t      op,
   input  logic     first_word,
   input  logic     cin,
   input  logic     carry_reg,
   output alu_ctl_t ctl
);

   always_comb begin
      ctl = '0;
      if (first_word) begin
         case (op)
            OP_SUB:  ctl.sub = 1'b1;
            OP_ADC:  begin ctl.adc = 1'b1; ctl.c = cin; end
            OP_SBB:  begin ctl.sbb = 1'b1; ctl.c = cin; end
            default: ;
         endcase
      end else begin
         // Subtracts keep the ALU's B inversion on every word; SBB carries the borrow.
         case (op)
            OP_SUB, OP_SBB: begin ctl.sbb = 1'b1; ctl.c = carry_reg; end
            default:        begin ctl.adc = 1'b1; ctl.c = carry_reg; end
         endcase
      end
   end

endmodule

// File: rtl/alu_mw_sequencer.sv
// Time-shares a 16-bit combinational ALU for WORDS x 16-bit ADD/SUB/ADC/SBB, LSW first.
// Optional macro ALU_MW_SEQ_ABORT_EN adds an abort input that cancels RUN/DONE.
module alu_mw_sequencer
   import alu_seq_pkg::*;
#(
   parameter  int WORDS = 2,
   localparam int W     = WORD_W * WORDS,
   localparam int IDX_W = $clog2(WORDS)
) (
   input  logic              clk,
   input  logic              rst,
`ifdef ALU_MW_SEQ_ABORT_EN
   input  logic              abort,
`endif
   input  logic              start,
   input  logic [1:0]        op,
   input  logic              cin,
   input  logic [W-1:0]      opa,
   input  logic [W-1:0]      opb,
   output logic              busy,
   output logic              done,
   output logic [W-1:0]      result,
   output logic              carry,
   output logic              ovf,
   output logic              zero,
   output logic [WORD_W-1:0] alu_a,
   output logic [WORD_W-1:0] alu_b,
   output logic              alu_sub,
   output logic              alu_sbb,
   output logic              alu_adc,
   output logic              alu_c,
   input  logic [WORD_W-1:0] alu_y,
   input  logic              alu_cout,
   input  logic              alu_cout1
);

   state_t           state, state_nxt;
   op_t              op_q;
   logic [W-1:0]     opa_q, opb_q, res_nxt;
   logic             cin_q, carry_reg;
   logic [IDX_W-1:0] idx;
   logic             run, last, abort_w;
   alu_ctl_t         ctl;

`ifdef ALU_MW_SEQ_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   assign run  = (state == S_RUN);
   assign last = (idx == IDX_W'(WORDS - 1));
   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE) && !abort_w;

   alu_mw_ctl_decode u_decode (
      .op         (op_q),
      .first_word (idx == '0),
      .cin        (cin_q),
      .carry_reg  (carry_reg),
      .ctl        (ctl)
   );

   // ALU inputs are only live in RUN so the shared ALU sees zeros otherwise.
   assign alu_a   = run ? opa_q[WORD_W*idx +: WORD_W] : '0;
   assign alu_b   = run ? opb_q[WORD_W*idx +: WORD_W] : '0;
   assign alu_sub = run & ctl.sub;
   assign alu_sbb = run & ctl.sbb;
   assign alu_adc = run & ctl.adc;
   assign alu_c   = run & ctl.c;

   always_comb begin
      res_nxt = result;
      res_nxt[WORD_W*idx +: WORD_W] = alu_y;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (last)  state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (abort_w && state != S_IDLE) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         op_q      <= OP_ADD;
         opa_q     <= '0;
         opb_q     <= '0;
         cin_q     <= 1'b0;
         idx       <= '0;
         carry_reg <= 1'b0;
         result    <= '0;
         carry     <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (abort_w && state != S_IDLE) begin
            result <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
         end else begin
            case (state)
               S_IDLE: if (start) begin
                  opa_q     <= opa;
                  opb_q     <= opb;
                  op_q      <= op_t'(op);
                  cin_q     <= cin;
                  idx       <= '0;
                  carry_reg <= 1'b0;
                  result    <= '0;
                  carry     <= 1'b0;
                  ovf       <= 1'b0;
                  zero      <= 1'b0;
               end
               S_RUN: begin
                  result    <= res_nxt;
                  carry_reg <= alu_cout;
                  idx       <= idx + 1'b1;
                  // Flags come from the top word; zero is judged on the fully assembled value.
                  if (last) begin
                     carry <= alu_cout;
                     ovf   <= alu_cout ^ alu_cout1;
                     zero  <= (res_nxt == '0);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_mw_sequencer.sv
// Bench for alu_mw_sequencer (WORDS=2) with a behavioural 16-bit ALU attached;
// results are compared against whole-width arithmetic.
module tb_alu_mw_sequencer;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst, start, cin;
   logic [1:0]    op;
   logic [W-1:0]  opa, opb;
   logic          busy, done, carry, ovf, zero;
   logic [W-1:0]  result;
   logic [15:0]   alu_a, alu_b, alu_y;
   logic          alu_sub, alu_sbb, alu_adc, alu_c, alu_cout, alu_cout1;
`ifdef ALU_MW_SEQ_ABORT_EN
   logic          abort = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_mw_sequencer #(.WORDS(2)) dut (
      .clk(clk), .rst(rst),
`ifdef ALU_MW_SEQ_ABORT_EN
      .abort(abort),
`endif
      .start(start), .op(op), .cin(cin), .opa(opa), .opb(opb),
      .busy(busy), .done(done), .result(result), .carry(carry), .ovf(ovf), .zero(zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub), .alu_sbb(alu_sbb),
      .alu_adc(alu_adc), .alu_c(alu_c), .alu_y(alu_y), .alu_cout(alu_cout),
      .alu_cout1(alu_cout1)
   );

   // External ALU: Y = A + (B or ~B) + carry-in; Cout_1 is the carry into bit 15.
   logic [15:0] alu_bb;
   logic        alu_ci;
   logic [16:0] alu_sum;
   logic [15:0] alu_low;
   always_comb begin
      alu_bb    = (alu_sub | alu_sbb) ? ~alu_b : alu_b;
      alu_ci    = alu_sub ? 1'b1 : ((alu_sbb | alu_adc) ? alu_c : 1'b0);
      alu_sum   = {1'b0, alu_a} + {1'b0, alu_bb} + 17'(alu_ci);
      alu_low   = {1'b0, alu_a[14:0]} + {1'b0, alu_bb[14:0]} + 16'(alu_ci);
      alu_y     = alu_sum[15:0];
      alu_cout  = alu_sum[16];
      alu_cout1 = alu_low[15];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: {ovf, carry, result} from full-width two's-complement arithmetic.
   function automatic logic [W+1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic ci);
      logic [W-1:0] bb;
      logic         c0, v;
      logic [W:0]   s;
      bb = (o == 2'd1 || o == 2'd3) ? ~b : b;
      c0 = (o == 2'd0) ? 1'b0 : (o == 2'd1) ? 1'b1 : ci;
      s  = {1'b0, a} + {1'b0, bb} + (W+1)'(c0);
      v  = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
      return {v, s[W], s[W-1:0]};
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ci);
      logic [W+1:0] m;
      logic [15:0]  bb0;
      logic [16:0]  low;
      logic         c0, sub_op;
      int           lat;
      m      = model(o, a, b, ci);
      sub_op = (o == 2'd1 || o == 2'd3);
      bb0    = sub_op ? ~b[15:0] : b[15:0];
      c0     = (o == 2'd0) ? 1'b0 : (o == 2'd1) ? 1'b1 : ci;
      low    = {1'b0, a[15:0]} + {1'b0, bb0} + 17'(c0);
      @(negedge clk);
      op = o; opa = a; opb = b; cin = ci; start = 1'b1;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            start = 1'b0;
            check("w0_a", 64'(alu_a), 64'(a[15:0]));
            check("w0_ctl", 64'({alu_sub, alu_sbb, alu_adc, alu_c}),
                  64'({o == 2'd1, o == 2'd3, o == 2'd2, (o[1] ? ci : 1'b0)}));
         end
         if (lat == 2) begin
            check("w1_b", 64'(alu_b), 64'(b[31:16]));
            check("w1_ctl", 64'({alu_sub, alu_sbb, alu_adc, alu_c}),
                  64'({1'b0, sub_op, !sub_op, low[16]}));
         end
         if (done) break;
      end
      check("latency", 64'(lat), 64'd3);
      check("result", 64'(result), 64'(m[W-1:0]));
      check("carry", 64'(carry), 64'(m[W]));
      check("ovf", 64'(ovf), 64'(m[W+1]));
      check("zero", 64'(zero), 64'(m[W-1:0] == '0));
      @(posedge clk);
      @(negedge clk);
      check("post_done", 64'({busy, done}), 64'd0);
      check("hold", 64'(result), 64'(m[W-1:0]));
   endtask

   // Accept an op, then cancel it in the idx=1 RUN cycle with either rst or abort.
   task automatic cancel_op(input bit use_abort);
      int dones;
      @(negedge clk);
      op = 2'd0; opa = 32'h0005_0003; opb = 32'h0001_0001; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("cancel_pre_busy", 64'(busy), 64'd1);
      check("cancel_pre_res", 64'(result[15:0]), 64'h4);
`ifdef ALU_MW_SEQ_ABORT_EN
      if (use_abort) abort = 1'b1; else rst = 1'b1;
`else
      rst = 1'b1;
`endif
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
`ifdef ALU_MW_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      check("cancel_busy", 64'(busy), 64'd0);
      check("cancel_result", 64'({result, carry, ovf, zero}), 64'd0);
      check("cancel_alu", 64'({alu_a, alu_sub, alu_sbb, alu_adc, alu_c}), 64'd0);
      dones = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) dones++;
      end
      check("cancel_nodone", 64'(dones), 64'd0);
   endtask

   initial begin
      int dones;
      rst = 1'b1; start = 1'b0; op = 2'd0; cin = 1'b0; opa = '0; opb = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_status", 64'({busy, done, carry, ovf, zero}), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_alu", 64'({alu_a, alu_b, alu_sub, alu_sbb, alu_adc, alu_c}), 64'd0);
      rst = 1'b0;

      // Directed corner cases.
      run_op(2'd0, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
      run_op(2'd1, 32'h0001_0000, 32'h0000_0001, 1'b0);
      run_op(2'd1, 32'h0000_0000, 32'h0000_0001, 1'b0);
      run_op(2'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      run_op(2'd1, 32'h8000_0000, 32'h0000_0001, 1'b0);
      run_op(2'd2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      run_op(2'd3, 32'h0000_0005, 32'h0000_0003, 1'b0);

      // Randomized operations, some with word-boundary operands.
      for (int i = 0; i < 24; i++) begin
         logic [W-1:0] a, b;
         a = $urandom;
         b = $urandom;
         if (i % 4 == 1) a[15:0] = 16'hFFFF;
         if (i % 4 == 2) b = a;
         run_op(2'($urandom_range(0, 3)), a, b, 1'($urandom_range(0, 1)));
      end

      // start held high: one done per accept, re-accept only from IDLE.
      @(negedge clk);
      op = 2'd0; opa = 32'd1; opb = 32'd2; cin = 1'b0; start = 1'b1;
      dones = 0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) dones++;
         if (i == 4) check("held_idle_gap", 64'({busy, done}), 64'd0);
         if (i == 7) check("held_second", 64'(result), 64'd3);
      end
      start = 1'b0;
      check("held_dones", 64'(dones), 64'd2);

      cancel_op(1'b0);
`ifdef ALU_MW_SEQ_ABORT_EN
      cancel_op(1'b1);
`endif
      run_op(2'd0, 32'h1234_5678, 32'h1111_1111, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
